// File: rtl/valve_pkg.sv
// rtl/valve_pkg.sv - shared opcodes, instruction field positions and FSM state encoding
package valve_pkg;

   localparam int IW = 21;
   localparam int AW = 8;
   localparam int DW = 10;

   localparam logic [2:0] OP_HALT  = 3'b000;
   localparam logic [2:0] OP_SET   = 3'b001;
   localparam logic [2:0] OP_DELAY = 3'b010;

   localparam int OPC_MSB = 20;
   localparam int OPC_LSB = 18;
   localparam int VLV_MSB = 17;
   localparam int VLV_LSB = 14;
   localparam int DLY_MSB = 13;
   localparam int DLY_LSB = 4;
   localparam int VAL_BIT = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_DELAY = 3'd3,
      ST_HALT  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

endpackage

// File: rtl/ms_delay_timer.sv
// rtl/ms_delay_timer.sv - millisecond delay timer: tick prescaler plus ms down-counter
module ms_delay_timer
   import valve_pkg::*;
#(
   parameter int CLKS_PER_MS = 100000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_load,
   input  logic [DW-1:0] i_count,
   output logic          o_expired
);

   localparam int TW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [TW-1:0] TICK_RELOAD = TW'(CLKS_PER_MS - 1);

   logic [TW-1:0] r_tick;
   logic [DW-1:0] r_ms;
   logic          r_active;

   // Expiry fires on the last tick of the last millisecond, so the owner leaves on that edge.
   assign o_expired = r_active && (r_tick == '0) && (r_ms == DW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick   <= '0;
         r_ms     <= '0;
         r_active <= 1'b0;
      end else if (i_clear) begin
         r_tick   <= '0;
         r_ms     <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_tick   <= TICK_RELOAD;
         r_ms     <= i_count;
         r_active <= (i_count != '0);
      end else if (r_active) begin
         if (r_tick == '0) begin
            r_tick <= TICK_RELOAD;
            r_ms   <= r_ms - DW'(1);
            if (r_ms == DW'(1)) begin
               r_active <= 1'b0;
               r_tick   <= '0;
            end
         end else begin
            r_tick <= r_tick - TW'(1);
         end
      end
   end

endmodule

// File: rtl/valve_sequencer.sv
// rtl/valve_sequencer.sv - fetch/decode/execute controller driving the valve bank
module valve_sequencer
   import valve_pkg::*;
#(
   parameter int          CLKS_PER_MS = 100000,
   parameter logic [7:0]  START_ADDR  = 8'd1,
   parameter int          NUM_VALVES  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic [AW-1:0]         imem_addr,
   input  logic [IW-1:0]         imem_data,
   output logic [NUM_VALVES-1:0] valve_o,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_t                r_state;
   state_t                w_next_state;
   logic [AW-1:0]         r_pc;
   logic [AW-1:0]         w_pc_next;
   logic [IW-1:0]         r_ir;
   logic [IW-1:0]         w_ir_next;
   logic [NUM_VALVES-1:0] r_valve;
   logic [NUM_VALVES-1:0] w_valve_next;
   logic                  w_tmr_load;
   logic                  w_tmr_clear;
   logic                  w_tmr_expired;

   logic [2:0]            w_opc;
   logic [3:0]            w_vidx;
   logic [DW-1:0]         w_dly;
   logic                  w_unused_ir;

   assign w_opc       = r_ir[OPC_MSB:OPC_LSB];
   assign w_vidx      = r_ir[VLV_MSB:VLV_LSB];
   assign w_dly       = r_ir[DLY_MSB:DLY_LSB];
   assign w_unused_ir = ^r_ir[DLY_LSB-1:VAL_BIT+1];

   ms_delay_timer #(
      .CLKS_PER_MS (CLKS_PER_MS)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_tmr_clear),
      .i_load    (w_tmr_load),
      .i_count   (w_dly),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
         r_valve <= '0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_pc_next;
         r_ir    <= w_ir_next;
         r_valve <= w_valve_next;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pc_next    = r_pc;
      w_ir_next    = r_ir;
      w_valve_next = r_valve;
      w_tmr_load   = 1'b0;
      w_tmr_clear  = 1'b0;

      // abort outranks start and every in-flight transition
      if (abort) begin
         w_next_state = ST_IDLE;
         w_valve_next = '0;
         w_tmr_clear  = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT, ST_ERROR: begin
               if (start) begin
                  w_pc_next    = START_ADDR;
                  w_next_state = ST_FETCH;
               end
            end
            ST_FETCH: begin
               w_ir_next    = imem_data;
               w_pc_next    = r_pc + AW'(1);
               w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
               case (w_opc)
                  OP_HALT: w_next_state = ST_HALT;
                  OP_SET: begin
                     // Indices past the implemented bank fall through as no-ops.
                     for (int i = 0; i < NUM_VALVES; i++) begin
                        if (32'(w_vidx) == i) begin
                           w_valve_next[i] = r_ir[VAL_BIT];
                        end
                     end
                     w_next_state = ST_FETCH;
                  end
                  OP_DELAY: begin
                     if (w_dly == '0) begin
                        w_next_state = ST_FETCH;
                     end else begin
                        w_tmr_load   = 1'b1;
                        w_next_state = ST_DELAY;
                     end
                  end
                  default: begin
                     w_valve_next = '0;
                     w_next_state = ST_ERROR;
                  end
               endcase
            end
            ST_DELAY: begin
               if (w_tmr_expired) begin
                  w_next_state = ST_FETCH;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   assign imem_addr = r_pc;
   assign valve_o   = r_valve;
   assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_DELAY);
   assign done      = (r_state == ST_HALT);
   assign error     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_valve_sequencer.sv
// tb/tb_valve_sequencer.sv - self-checking bench with instruction-level reference model
module tb_valve_sequencer;

   localparam int CPM = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [7:0]  imem_addr;
   logic [20:0] imem_data;
   logic [15:0] valve_o;
   logic        busy;
   logic        done;
   logic        error;

   logic [20:0] mem [256];
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   valve_sequencer #(
      .CLKS_PER_MS (CPM),
      .START_ADDR  (8'd1),
      .NUM_VALVES  (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .valve_o   (valve_o),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_v [$];
   int          exp_a [$];
   logic [15:0] m_valve;
   int          m_pc;
   int          m_end;
   int          watch_bit;
   int          hi_cnt;
   int          rise_k;
   logic        saw0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [20:0] i_op(input logic [2:0] op);
      logic [20:0] w;
      w = 21'($urandom);
      w[20:18] = op;
      return w;
   endfunction

   function automatic logic [20:0] i_set(input int idx, input logic val);
      logic [20:0] w;
      w = i_op(3'b001);
      w[17:14] = 4'(idx);
      w[0] = val;
      return w;
   endfunction

   function automatic logic [20:0] i_dly(input int n);
      logic [20:0] w;
      w = i_op(3'b010);
      w[13:4] = 10'(n);
      return w;
   endfunction

   // Instruction-level model: each instruction costs 2 cycles, a DELAY N costs 2 + N ms.
   task automatic model(input int limit);
      logic [20:0] w;
      int cost;
      exp_v.delete();
      exp_a.delete();
      m_pc  = 1;
      m_end = 0;
      while (m_end == 0 && exp_v.size() < limit) begin
         w = mem[m_pc];
         cost = (w[20:18] == 3'b010) ? 2 + int'(w[13:4]) * CPM : 2;
         for (int c = 0; c < cost; c++) begin
            exp_v.push_back(m_valve);
            exp_a.push_back(c == 0 ? m_pc : -1);
         end
         case (w[20:18])
            3'b000: m_end = 1;
            3'b001: m_valve[w[17:14]] = w[0];
            3'b010: ;
            default: begin m_valve = '0; m_end = 2; end
         endcase
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_check(input string tag, input int limit);
      model(limit);
      hi_cnt = 0;
      rise_k = -1;
      saw0   = 1'b0;
      pulse_start();
      for (int k = 0; k < exp_v.size(); k++) begin
         @(negedge clk);
         chk({tag, "_valve"}, valve_o, exp_v[k]);
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_done_err"}, {done, error}, 2'b00);
         if (exp_a[k] >= 0) begin
            chk({tag, "_addr"}, imem_addr, exp_a[k]);
            if (imem_addr == 8'd0) saw0 = 1'b1;
         end
         if (valve_o[watch_bit]) begin
            hi_cnt++;
            if (rise_k < 0) rise_k = k;
         end
      end
      if (m_end != 0) begin
         @(negedge clk);
         chk({tag, "_end_done"}, done, (m_end == 1));
         chk({tag, "_end_error"}, error, (m_end == 2));
         chk({tag, "_end_busy"}, busy, 1'b0);
         chk({tag, "_end_valve"}, valve_o, m_valve);
         chk({tag, "_end_addr"}, imem_addr, m_pc);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 21'd0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_valve = '0; watch_bit = 0;
      #12;
      chk("rst_outputs", {imem_addr, valve_o, busy, done, error}, '0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_quiet", {imem_addr, busy, done, error}, '0);

      // Test 1: SET v1=1; DELAY 2; SET v1=0; HALT
      mem[1] = i_set(1, 1'b1); mem[2] = i_dly(2); mem[3] = i_set(1, 1'b0); mem[4] = i_op(3'b000);
      watch_bit = 1;
      run_check("t1", 1000);
      chk("t1_v1_high_cycles", hi_cnt, 24);
      chk("t1_addr5", imem_addr, 8'd5);

      // Test 2: DELAY 0 then SET v3=1
      mem[1] = i_dly(0); mem[2] = i_set(3, 1'b1); mem[3] = i_op(3'b000);
      watch_bit = 3;
      run_check("t2", 1000);
      chk("t2_rise_cycle", rise_k, 4);

      // Test 3: SET v0=1 then illegal opcode, twice
      mem[1] = i_set(0, 1'b1); mem[2] = i_op(3'b111);
      watch_bit = 0;
      run_check("t3", 1000);
      chk("t3_v0_high_cycles", hi_cnt, 2);
      run_check("t3r", 1000);

      // Randomized programs ending in HALT or an illegal opcode
      for (int r = 0; r < 8; r++) begin
         int k;
         k = $urandom_range(2, 7);
         for (int j = 1; j < k; j++)
            mem[j] = ($urandom_range(0, 1) == 1) ? i_set($urandom_range(0, 15), 1'($urandom_range(0, 1)))
                                                 : i_dly($urandom_range(0, 3));
         mem[k] = ($urandom_range(0, 2) == 0) ? i_op(3'($urandom_range(3, 7))) : i_op(3'b000);
         run_check("rnd", 1000);
      end

      // Test 4: abort with simultaneous start in the middle of DELAY 5
      mem[1] = i_set(2, 1'b1); mem[2] = i_dly(5); mem[3] = i_op(3'b000);
      pulse_start();
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t4_pre_busy", busy, 1'b1);
      chk("t4_pre_v2", valve_o[2], 1'b1);
      @(posedge clk); #1 abort = 1'b1; start = 1'b1;
      @(posedge clk); #1 abort = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("t4_abort_outs", {valve_o, busy, done, error}, '0);
      repeat (5) @(negedge clk);
      chk("t4_start_ignored", {valve_o, busy}, '0);
      m_valve = '0;

      // Test 5: asynchronous reset during DELAY
      mem[1] = i_set(5, 1'b1); mem[2] = i_dly(5);
      pulse_start();
      repeat (15) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("t5_async_rst", {imem_addr, valve_o, busy, done, error}, '0);
      #3 rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("t5_no_activity", {imem_addr, valve_o, busy, done, error}, '0);
      m_valve = '0;

      // Test 6: memory full of SET, PC wraps
      for (int a = 0; a < 256; a++) mem[a] = i_set($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      watch_bit = 0;
      run_check("t6", 600);
      chk("t6_wrapped", saw0, 1'b1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("t6_abort", {valve_o, busy}, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
